// File: rtl/psum_accum_quant.sv
// Partial-sum accumulator and int8 requantizer with an output FIFO.
// Define PSUM_RELU_EN to clamp negative requantized values to zero before the zero point is added.
module psum_accum_quant #(
    parameter int ACC_W      = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] psum_in,
    input  logic               psum_valid,
    input  logic               clear,
    input  logic [7:0]         cfg_acc_len,
    input  logic [15:0]        cfg_scale,
    input  logic [5:0]         cfg_shift,
    input  logic signed [7:0]  cfg_zp,
    output logic signed [7:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               ovf
);
    localparam int PROD_W = ACC_W + 17;
    localparam int RND_W  = (ACC_W + 18 > 65) ? ACC_W + 18 : 65;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam logic signed [RND_W-1:0] MAX_V = 127;
    localparam logic signed [RND_W-1:0] MIN_V = -128;

    logic signed [ACC_W-1:0] acc, psum_ext, total;
    logic [7:0]              cnt, len_q, len_raw, len_eff;
    logic [15:0]             scale_q, scale_eff;
    logic [5:0]              shift_q, shift_eff;
    logic signed [7:0]       zp_q, zp_eff;
    logic                    take, first, last;

    // The first psum of a group uses the live cfg; later psums use the copy latched with it.
    always_comb begin
        first     = (cnt == 8'd0);
        len_raw   = first ? cfg_acc_len : len_q;
        len_eff   = (len_raw == 8'd0) ? 8'd1 : len_raw;
        scale_eff = first ? cfg_scale : scale_q;
        shift_eff = first ? cfg_shift : shift_q;
        zp_eff    = first ? cfg_zp    : zp_q;
        take      = psum_valid && !clear;
        last      = take && (cnt == len_eff - 8'd1);
        psum_ext  = {{(ACC_W-32){psum_in[31]}}, psum_in};
        total     = acc + psum_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            scale_q <= '0;
            shift_q <= '0;
            zp_q    <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            if (first) begin
                len_q   <= cfg_acc_len;
                scale_q <= cfg_scale;
                shift_q <= cfg_shift;
                zp_q    <= cfg_zp;
            end
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= total;
                cnt <= cnt + 8'd1;
            end
        end
    end

    // S1: total and the group's cfg, product formed combinationally into S2.
    logic                    s1_v, s2_v;
    logic signed [ACC_W-1:0] s1_total;
    logic [15:0]             s1_scale;
    logic [5:0]              s1_shift, s2_shift;
    logic signed [7:0]       s1_zp, s2_zp;
    logic signed [PROD_W-1:0] total_x, scale_x, prod, s2_prod;

    assign total_x = {{17{s1_total[ACC_W-1]}}, s1_total};
    assign scale_x = {{(ACC_W+1){1'b0}}, s1_scale};
    assign prod    = total_x * scale_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v     <= 1'b0;
            s1_total <= '0;
            s1_scale <= '0;
            s1_shift <= '0;
            s1_zp    <= '0;
            s2_v     <= 1'b0;
            s2_prod  <= '0;
            s2_shift <= '0;
            s2_zp    <= '0;
        end else begin
            s1_v <= last;
            s2_v <= s1_v && !clear;
            if (last) begin
                s1_total <= total;
                s1_scale <= scale_eff;
                s1_shift <= shift_eff;
                s1_zp    <= zp_eff;
            end
            if (s1_v) begin
                s2_prod  <= prod;
                s2_shift <= s1_shift;
                s2_zp    <= s1_zp;
            end
        end
    end

    // S2: round-half-up shift, optional ReLU, zero point, saturate to int8.
    logic signed [RND_W-1:0] prod_x, rnd, sum, r, v;
    logic signed [7:0]       q_val;

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        prod_x = {{(RND_W-PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
        rnd    = '0;
        if (s2_shift != 6'd0)
            rnd = RND_W'(1) << (s2_shift - 6'd1);
        sum = prod_x + rnd;
        r   = sum >>> s2_shift;
`ifdef PSUM_RELU_EN
        if (r[RND_W-1])
            r = '0;
`endif
        v = r + {{(RND_W-8){s2_zp[7]}}, s2_zp};
        if (v > MAX_V)
            q_val = 8'sd127;
        else if (v < MIN_V)
            q_val = -8'sd128;
        else
            q_val = v[7:0];
    end

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, push, drop;

    always_comb begin
        out_valid = (wr_ptr != rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = out_valid && out_ready;
        push      = s2_v && (!full || pop);
        drop      = s2_v && full && !pop;
        out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 8'sd0;
        busy      = (cnt != 8'd0) || s1_v || s2_v;
    end

    // NOTE: storage has no reset; empty pointers gate out_data, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= q_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_accum_quant.sv
// Directed self-checking bench for psum_accum_quant; expectations follow PSUM_RELU_EN when defined.
module tb_psum_accum_quant;
`ifdef PSUM_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] psum_in;
    logic               psum_valid;
    logic               clear;
    logic [7:0]         cfg_acc_len;
    logic [15:0]        cfg_scale;
    logic [5:0]         cfg_shift;
    logic signed [7:0]  cfg_zp;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    psum_accum_quant dut (
        .clk         (clk),
        .rst         (rst),
        .psum_in     (psum_in),
        .psum_valid  (psum_valid),
        .clear       (clear),
        .cfg_acc_len (cfg_acc_len),
        .cfg_scale   (cfg_scale),
        .cfg_shift   (cfg_shift),
        .cfg_zp      (cfg_zp),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one psum for exactly one rising edge; returns 1ns after that edge.
    task automatic send(input int val);
        psum_in    = val;
        psum_valid = 1'b1;
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
    endtask

    task automatic set_cfg(input int len, input int scale, input int shift, input int zp);
        cfg_acc_len = 8'(len);
        cfg_scale   = 16'(scale);
        cfg_shift   = 6'(shift);
        cfg_zp      = 8'(zp);
    endtask

    initial begin
        rst        = 1'b0;
        psum_in    = '0;
        psum_valid = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        set_cfg(0, 0, 0, 0);
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b1;
        step(1);

        // Accumulate 10+20+30+40; cfg changes after the first psum must be ignored.
        out_ready = 1'b1;
        set_cfg(4, 3, 2, -5);
        send(10);
        set_cfg(1, 7, 0, 0);
        send(20);
        check("acc_busy_mid", int'(busy), 1);
        send(30);
        send(40);
        check("lat_e0", int'(out_valid), 0);
        step(1);
        check("lat_e1", int'(out_valid), 0);
        step(1);
        check("lat_e2", int'(out_valid), 1);
        check("acc_data", int'(out_data), 70);
        check("acc_busy_done", int'(busy), 0);
        step(1);
        check("acc_popped", int'(out_valid), 0);

        // Negative total: -100*3 = -300, (-300+2)>>>2 = -75.
        set_cfg(4, 3, 2, 0);
        send(-10);
        send(-20);
        send(-30);
        send(-40);
        step(2);
        check("neg_valid", int'(out_valid), 1);
        check("neg_data", int'(out_data), RELU ? 0 : -75);
        step(1);

        // Saturation, back to back at one group per cycle.
        set_cfg(1, 1, 0, 0);
        send(1000);
        send(-1000);
        step(1);
        check("sat_hi", int'(out_data), 127);
        step(1);
        check("sat_lo_valid", int'(out_valid), 1);
        check("sat_lo", int'(out_data), RELU ? 0 : -128);
        step(1);
        check("sat_empty", int'(out_valid), 0);

        // Backpressure: five results into a four-entry FIFO.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(k);
        step(2);
        check("bp_ovf", int'(ovf), 1);
        check("bp_valid", int'(out_valid), 1);
        check("bp_head_stable", int'(out_data), 1);
        step(1);
        check("bp_head_held", int'(out_data), 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("bp_pop%0d", k), int'(out_data), k);
            step(1);
        end
        check("bp_drained", int'(out_valid), 0);
        check("bp_ovf_sticky", int'(ovf), 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("bp_ovf_cleared", int'(ovf), 0);

        // Interrupted group: clear discards the partial sum and its own psum.
        set_cfg(4, 1, 0, 0);
        send(5);
        send(6);
        clear = 1'b1;
        send(100);
        clear = 1'b0;
        check("int_busy_cleared", int'(busy), 0);
        for (int k = 0; k < 4; k++) send(1);
        check("int_not_yet", int'(out_valid), 0);
        step(2);
        check("int_valid", int'(out_valid), 1);
        check("int_data", int'(out_data), 4);
        step(1);
        check("int_single", int'(out_valid), 0);

        // Asynchronous reset mid-group with two entries buffered.
        out_ready = 1'b0;
        set_cfg(1, 1, 0, 0);
        send(7);
        send(8);
        set_cfg(4, 1, 0, 0);
        send(1);
        send(2);
        check("ar_pre_valid", int'(out_valid), 1);
        check("ar_pre_busy", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_out_valid", int'(out_valid), 0);
        check("ar_out_data", int'(out_data), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        out_ready = 1'b1;
        set_cfg(1, 2, 1, 3);
        send(9);
        step(2);
        check("ar_fresh_valid", int'(out_valid), 1);
        check("ar_fresh_data", int'(out_data), 12);
        step(1);
        check("ar_fresh_empty", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
